// File: rtl/usb_rx_fifo.sv
// usb_rx_fifo
//
// USB full-speed receive path with a payload FIFO. Raw D+/D- are synchronised,
// sampled mid-bit by a bit timer that re-locks on every D+ edge, NRZI decoded
// and unstuffed. A framing FSM checks SYNC and PID, optionally checks CRC16 on
// data packets, and pushes every decoded byte after the PID into a
// first-word-fall-through FIFO.
//
// Ports:
//   clk         system clock, rising edge
//   n_rst       asynchronous active-low reset
//   d_plus      raw D+ line (asynchronous)
//   d_minus     raw D- line (asynchronous)
//   r_enable    pop the FIFO head (ignored when empty)
//   r_data      FIFO head, 8'h00 when empty
//   empty/full  FIFO occupancy flags
//   rcving      high while a packet is being received
//   r_error     sticky packet error (bad SYNC/PID, stuff error, truncation, overflow)
//   PID         last valid PID
//   pkt_done    one-cycle pulse on a clean end of packet
//   crc_error   sticky CRC16 failure of the last data packet
//   byte_count  current FIFO occupancy

module usb_rx_fifo #(
    parameter int CLKS_PER_BIT = 8,
    parameter int FIFO_DEPTH   = 64,
    parameter bit CRC_CHECK    = 1'b1,
    localparam int CW          = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          d_plus,
    input  logic          d_minus,
    input  logic          r_enable,
    output logic [7:0]    r_data,
    output logic          empty,
    output logic          full,
    output logic          rcving,
    output logic          r_error,
    output logic [3:0]    PID,
    output logic          pkt_done,
    output logic          crc_error,
    output logic [CW-1:0] byte_count
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int TW   = $clog2(CLKS_PER_BIT);
    localparam int PW   = $clog2(FIFO_DEPTH);

    localparam logic [TW-1:0] TIMER_LAST   = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TIMER_SAMPLE = TW'(HALF - 1);
    localparam logic [CW-1:0] DEPTH_CNT    = CW'(FIFO_DEPTH);
    localparam logic [15:0]   CRC_RESIDUAL = 16'h800D;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_DATA,
        ST_EOP,
        ST_ERR
    } state_t;

    state_t state, state_next;

    // ------------------------------------------------------------------
    // Input synchronisers and line decode
    // ------------------------------------------------------------------
    logic dp_meta, dp_sync, dp_last;
    logic dm_meta, dm_sync;

    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_meta <= 1'b1;
            dp_sync <= 1'b1;
            dp_last <= 1'b1;
            dm_meta <= 1'b0;
            dm_sync <= 1'b0;
        end else begin
            dp_meta <= d_plus;
            dp_sync <= dp_meta;
            dp_last <= dp_sync;
            dm_meta <= d_minus;
            dm_sync <= dm_meta;
        end
    end

    logic dp_edge, se0, j_state;
    assign dp_edge = dp_sync != dp_last;
    assign se0     = !dp_sync && !dm_sync;
    assign j_state = dp_sync && !dm_sync;

    // Bit timer: re-locked to zero on every D+ transition, so the sample
    // point sits HALF clocks after the observed edge.
    logic [TW-1:0] bit_timer;
    logic          shift_en;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_timer <= '0;
        end else if (dp_edge || bit_timer == TIMER_LAST) begin
            bit_timer <= '0;
        end else begin
            bit_timer <= bit_timer + TW'(1);
        end
    end

    assign shift_en = bit_timer == TIMER_SAMPLE;

    // ------------------------------------------------------------------
    // NRZI decode, unstuffing and byte assembly
    // ------------------------------------------------------------------
    logic       nrzi_prev;
    logic [2:0] ones_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic [15:0] crc;
    logic       se0_seen;

    logic       dec_bit, in_frame, bit_sample, stuff_drop, stuff_err;
    logic       bit_kept, byte_done, crc_fb;
    logic [7:0] byte_next;

    assign dec_bit    = dp_sync == nrzi_prev;
    assign in_frame   = (state == ST_SYNC) || (state == ST_PID) || (state == ST_DATA);
    // An SE0 sample in DATA is an end-of-packet marker, not a data bit.
    assign bit_sample = shift_en && in_frame && !((state == ST_DATA) && se0);
    assign stuff_drop = ones_cnt == 3'd6;
    assign stuff_err  = bit_sample && stuff_drop && dec_bit;
    assign bit_kept   = bit_sample && !stuff_drop;
    assign byte_done  = bit_kept && (bit_cnt == 3'd7);
    assign byte_next  = {dec_bit, shift_reg[7:1]};
    assign crc_fb     = dec_bit ^ crc[15];

    // ------------------------------------------------------------------
    // Framing FSM
    // ------------------------------------------------------------------
    logic set_err_fsm, clr_err, pid_load, crc_init, byte_push, finish;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        set_err_fsm = 1'b0;
        clr_err     = 1'b0;
        pid_load    = 1'b0;
        crc_init    = 1'b0;
        byte_push   = 1'b0;
        finish      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (dp_edge && !dp_sync) state_next = ST_SYNC;
            end
            ST_SYNC: begin
                if (stuff_err) begin
                    state_next  = ST_ERR;
                    set_err_fsm = 1'b1;
                end else if (byte_done) begin
                    if (byte_next == 8'h80) begin
                        state_next = ST_PID;
                        clr_err    = 1'b1;
                    end else begin
                        state_next  = ST_ERR;
                        set_err_fsm = 1'b1;
                    end
                end
            end
            ST_PID: begin
                if (stuff_err) begin
                    state_next  = ST_ERR;
                    set_err_fsm = 1'b1;
                end else if (byte_done) begin
                    if (byte_next[3:0] == ~byte_next[7:4]) begin
                        state_next = ST_DATA;
                        pid_load   = 1'b1;
                        crc_init   = 1'b1;
                    end else begin
                        state_next  = ST_ERR;
                        set_err_fsm = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (shift_en && se0) begin
                    if (bit_cnt == 3'd0) begin
                        state_next = ST_EOP;
                    end else begin
                        state_next  = ST_ERR;
                        set_err_fsm = 1'b1;
                    end
                end else if (stuff_err) begin
                    state_next  = ST_ERR;
                    set_err_fsm = 1'b1;
                end else if (byte_done) begin
                    byte_push = 1'b1;
                end
            end
            ST_EOP: begin
                if (j_state) begin
                    state_next = ST_IDLE;
                    finish     = 1'b1;
                end
            end
            ST_ERR: begin
                if (se0_seen && j_state) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO control (declared early: overflow feeds r_error)
    // ------------------------------------------------------------------
    logic          push_valid;
    logic [7:0]    push_data;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          do_push, do_pop, overflow;

    assign empty    = count == '0;
    assign full     = count == DEPTH_CNT;
    assign do_pop   = r_enable && !empty;
    assign do_push  = push_valid && (!full || do_pop);
    assign overflow = push_valid && full && !do_pop;

    // ------------------------------------------------------------------
    // Receive datapath and packet status
    // ------------------------------------------------------------------
    logic [3:0] pid_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            nrzi_prev  <= 1'b1;
            ones_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            crc        <= 16'hFFFF;
            pid_q      <= '0;
            r_error    <= 1'b0;
            crc_error  <= 1'b0;
            pkt_done   <= 1'b0;
            push_valid <= 1'b0;
            push_data  <= '0;
            se0_seen   <= 1'b0;
        end else begin
            pkt_done   <= finish;
            push_valid <= byte_push;
            push_data  <= byte_next;

            if (state == ST_IDLE) begin
                nrzi_prev <= 1'b1;
                ones_cnt  <= '0;
                bit_cnt   <= '0;
            end else begin
                if (shift_en) nrzi_prev <= dp_sync;
                if (bit_sample) begin
                    ones_cnt <= (stuff_drop || !dec_bit) ? 3'd0 : ones_cnt + 3'd1;
                end
                if (bit_kept) begin
                    shift_reg <= byte_next;
                    bit_cnt   <= bit_cnt + 3'd1;
                end
            end

            if (crc_init) begin
                crc <= 16'hFFFF;
            end else if ((state == ST_DATA) && bit_kept) begin
                crc <= {crc[14:0], 1'b0} ^ (crc_fb ? 16'h8005 : 16'h0000);
            end

            if (pid_load) pid_q <= byte_next[3:0];

            if (set_err_fsm || overflow) begin
                r_error <= 1'b1;
            end else if (clr_err) begin
                r_error <= 1'b0;
            end

            if (clr_err) begin
                crc_error <= 1'b0;
            end else if (finish && CRC_CHECK && (pid_q[1:0] == 2'b11) && (crc != CRC_RESIDUAL)) begin
                crc_error <= 1'b1;
            end

            // ERR must see SE0 before the J that ends the broken packet.
            if (state != ST_ERR) begin
                se0_seen <= 1'b0;
            end else if (se0) begin
                se0_seen <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Payload FIFO
    // ------------------------------------------------------------------
    logic [7:0] mem [FIFO_DEPTH];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; empty gates r_data, so stale
    // contents are never visible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign r_data     = empty ? 8'h00 : mem[rd_ptr];
    assign byte_count = count;
    assign rcving     = state != ST_IDLE;
    assign PID        = pid_q;

endmodule
